// File: rtl/game_score.sv
// Frame-rate score keeper and round FSM: BCD scoring, life-loss flash, round restart pulse.
// Optional pause state is built in when GAME_SCORE_PAUSE_EN is defined.
module game_score #(
    parameter int unsigned MET_POINTS   = 1,
    parameter int unsigned STAR_POINTS  = 5,
    parameter logic [15:0] WIN_SCORE    = 16'h0100,
    parameter logic [5:0]  FLASH_FRAMES = 6'd30
) (
    input  logic        v_sync,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        m1_alive,
    input  logic        m2_alive,
    input  logic        m3_alive,
    input  logic        s1_alive,
    input  logic        s2_alive,
    input  logic [1:0]  lives,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic [2:0]  state,
    output logic        game_run,
    output logic        round_rst,
    output logic        ship_flash
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_OVER  = 3'd2,
        ST_WIN   = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [15:0] hi_q, hi_d;
    logic [5:0]  flash_q, flash_d;
    logic        rr_q, rr_d;
    logic [4:0]  prev_alive_q;
    logic [1:0]  prev_lives_q;
    logic        prev_start_q;
    logic        prev_pause_q;

    logic [4:0]  alive_cur;
    logic [4:0]  fell;
    logic [1:0]  nk;
    logic [1:0]  ns;
    logic [7:0]  inc;
    logic [11:0] inc_bcd;
    logic [15:0] addend;
    logic [15:0] sum_bcd;
    logic [15:0] sum_sat;
    logic [4:0]  digit_raw;
    logic        digit_carry;
    logic        start_press;
    logic        pause_press;

    // Binary-to-BCD by shift-and-add-3; inc never exceeds 250 so three digits suffice.
    function automatic logic [11:0] bin_to_bcd(input logic [7:0] b);
        logic [11:0] bcd;
        bcd = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], b[i]};
        end
        return bcd;
    endfunction

    assign alive_cur   = {s2_alive, s1_alive, m3_alive, m2_alive, m1_alive};
    assign fell        = prev_alive_q & ~alive_cur;
    assign nk          = {1'b0, fell[0]} + {1'b0, fell[1]} + {1'b0, fell[2]};
    assign ns          = {1'b0, fell[3]} + {1'b0, fell[4]};
    assign inc         = 8'(32'(nk) * MET_POINTS + 32'(ns) * STAR_POINTS);
    assign inc_bcd     = bin_to_bcd(inc);
    assign addend      = {4'd0, inc_bcd};
    assign start_press = start_btn & ~prev_start_q;
    assign pause_press = pause_btn & ~prev_pause_q;

    // Digit-serial decimal add; a carry out of the thousands digit saturates.
    always_comb begin
        sum_bcd     = '0;
        digit_raw   = '0;
        digit_carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            digit_raw   = {1'b0, score_q[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'd0, digit_carry};
            digit_carry = (digit_raw > 5'd9);
            sum_bcd[4*i +: 4] = digit_carry ? 4'(digit_raw - 5'd10) : digit_raw[3:0];
        end
        sum_sat = digit_carry ? 16'h9999 : sum_bcd;
    end

`ifndef GAME_SCORE_PAUSE_EN
    logic pause_unused;
    assign pause_unused = pause_press;
`endif

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        hi_d    = hi_q;
        flash_d = flash_q;
        rr_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start_press) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    flash_d = '0;
                    rr_d    = 1'b1;
                end
            end
            ST_PLAY: begin
                // The restart frame is left alone: collision state may still be from the last round.
                if (!rr_q) begin
                    score_d = sum_sat;
                    if (lives < prev_lives_q)
                        flash_d = FLASH_FRAMES;
                    else if (flash_q != 6'd0)
                        flash_d = flash_q - 6'd1;
                    if (lives == 2'd0)
                        state_d = ST_OVER;
                    else if (score_q >= WIN_SCORE)
                        state_d = ST_WIN;
`ifdef GAME_SCORE_PAUSE_EN
                    else if (pause_press)
                        state_d = ST_PAUSE;
`endif
                    if ((state_d == ST_OVER || state_d == ST_WIN) && score_d > hi_q)
                        hi_d = score_d;
                end
            end
`ifdef GAME_SCORE_PAUSE_EN
            ST_PAUSE: begin
                if (pause_press)
                    state_d = ST_PLAY;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge v_sync or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            hi_q         <= '0;
            flash_q      <= '0;
            rr_q         <= 1'b0;
            prev_alive_q <= 5'b11111;
            prev_lives_q <= 2'd2;
            prev_start_q <= 1'b0;
            prev_pause_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            flash_q      <= flash_d;
            rr_q         <= rr_d;
            prev_alive_q <= alive_cur;
            prev_lives_q <= lives;
            prev_start_q <= start_btn;
            prev_pause_q <= pause_btn;
        end
    end

    assign score      = score_q;
    assign hi_score   = hi_q;
    assign state      = state_q;
    assign game_run   = (state_q == ST_PLAY);
    assign round_rst  = rr_q;
    assign ship_flash = (flash_q != 6'd0) & flash_q[2];

endmodule

// File: tb/tb_game_score.sv
// Scoreboarded bench for game_score: an integer-arithmetic game model queues expected frame
// outputs, a monitor compares them after each v_sync edge.
`timescale 1ns/1ps
module tb_game_score;

    localparam int          MET     = 37;
    localparam int          STAR    = 49;
    localparam logic [15:0] WIN_BCD = 16'h9990;
    localparam int          WIN_INT = 9990;
    localparam int          FLASH   = 30;
`ifdef GAME_SCORE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic        v_sync = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic [4:0]  alive = 5'h1f;
    logic [1:0]  lives = 2'd2;
    logic [15:0] score, hi_score;
    logic [2:0]  state;
    logic        game_run, round_rst, ship_flash;

    game_score #(
        .MET_POINTS(MET), .STAR_POINTS(STAR), .WIN_SCORE(WIN_BCD), .FLASH_FRAMES(6'd30)
    ) dut (
        .v_sync(v_sync), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .m1_alive(alive[0]), .m2_alive(alive[1]), .m3_alive(alive[2]),
        .s1_alive(alive[3]), .s2_alive(alive[4]), .lives(lives),
        .score(score), .hi_score(hi_score), .state(state), .game_run(game_run),
        .round_rst(round_rst), .ship_flash(ship_flash)
    );

    always #5 v_sync = ~v_sync;

    typedef struct {
        int          st;
        logic [15:0] sc;
        logic [15:0] hi;
        bit          run;
        bit          rr;
        bit          fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   frame_no = 0;

    // Model: plain integers for score and game state
    int       m_st, m_score, m_hi, m_flash, m_plives;
    bit       m_rr, m_pstart, m_ppause;
    bit [4:0] m_palive;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s frame %0d: got %h expected %h", name, frame_no, act, req);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_score = 0; m_hi = 0; m_flash = 0; m_rr = 1'b0;
        m_palive = 5'b11111; m_plives = 2; m_pstart = 1'b0; m_ppause = 1'b0;
    endtask

    task automatic model_step();
        bit sp, pp, new_rr;
        int nk, ns, inc, nst, old;
        exp_t e;
        sp = start_btn && !m_pstart;
        pp = pause_btn && !m_ppause;
        nk = 0; ns = 0;
        for (int i = 0; i < 3; i++) if (m_palive[i] && !alive[i]) nk++;
        for (int i = 3; i < 5; i++) if (m_palive[i] && !alive[i]) ns++;
        inc = nk * MET + ns * STAR;
        nst = m_st;
        new_rr = 1'b0;
        if (m_st == 0 || m_st == 2 || m_st == 3) begin
            if (sp) begin
                nst = 1; m_score = 0; m_flash = 0; new_rr = 1'b1;
            end
        end else if (m_st == 1) begin
            if (!m_rr) begin
                old = m_score;
                m_score = (old + inc > 9999) ? 9999 : old + inc;
                if (int'(lives) < m_plives) m_flash = FLASH;
                else if (m_flash > 0) m_flash--;
                if (lives == 2'd0) nst = 2;
                else if (old >= WIN_INT) nst = 3;
                else if (PAUSE_EN && pp) nst = 4;
                if ((nst == 2 || nst == 3) && m_score > m_hi) m_hi = m_score;
            end
        end else if (m_st == 4) begin
            if (pp) nst = 1;
        end
        m_st = nst;
        m_rr = new_rr;
        m_palive = alive;
        m_plives = int'(lives);
        m_pstart = start_btn;
        m_ppause = pause_btn;
        e.st = m_st; e.sc = to_bcd(m_score); e.hi = to_bcd(m_hi);
        e.run = (m_st == 1); e.rr = m_rr; e.fl = (m_flash != 0) && ((m_flash & 4) != 0);
        exp_q.push_back(e);
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic frame();
        model_step();
        @(negedge v_sync);
    endtask

    task automatic check_reset_state();
        check("rst_state", {13'd0, state}, 16'd0);
        check("rst_score", score, 16'h0000);
        check("rst_hi", hi_score, 16'h0000);
        check("rst_rr", {15'd0, round_rst}, 16'd0);
        check("rst_flash", {15'd0, ship_flash}, 16'd0);
        check("rst_run", {15'd0, game_run}, 16'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge v_sync);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                frame_no++;
                $display("frame %0d st=%0d score=%h hi=%h run=%b rr=%b flash=%b",
                         frame_no, state, score, hi_score, game_run, round_rst, ship_flash);
                check("state", {13'd0, state}, 16'(e.st));
                check("score", score, e.sc);
                check("hi_score", hi_score, e.hi);
                check("game_run", {15'd0, game_run}, {15'd0, e.run});
                check("round_rst", {15'd0, round_rst}, {15'd0, e.rr});
                check("ship_flash", {15'd0, ship_flash}, {15'd0, e.fl});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #1;
        check_reset_state();
        @(negedge v_sync);
        @(negedge v_sync);
        rst = 1'b0;
        model_reset();

        frame();
        // start press, then hold: exactly one round_rst pulse
        start_btn = 1'b1; frame(); frame(); frame();
        start_btn = 1'b0; frame();
        // single meteor, then three objects in one frame, then fall after regeneration
        alive[0] = 1'b0; frame();
        alive = 5'b10000; frame();
        alive = 5'h1f; frame();
        alive[0] = 1'b0; frame();
        alive = 5'h1f; frame();
        // life loss: flash run-out, then loss to zero goes straight to OVER
        lives = 2'd1; frame();
        for (int i = 0; i < 33; i++) frame();
        lives = 2'd0; frame(); frame();
        // restart keeps hi score, then drive to saturation and WIN
        lives = 2'd2; start_btn = 1'b1; frame();
        start_btn = 1'b0; frame();
        for (int i = 0; i < 50; i++) begin
            alive = 5'h00; frame();
            alive = 5'h1f; frame();
        end
        start_btn = 1'b1; frame();
        start_btn = 1'b0; frame(); frame();
        // pause toggle with a meteor fall while (possibly) paused
        pause_btn = 1'b1; frame();
        pause_btn = 1'b0; alive[0] = 1'b0; frame();
        alive = 5'h1f; frame();
        pause_btn = 1'b1; frame();
        pause_btn = 1'b0; frame();
        alive[1] = 1'b0; frame();
        alive = 5'h1f; frame();
        // asynchronous reset mid-round, between v_sync edges
        rst = 1'b1;
        #1;
        check_reset_state();
        @(negedge v_sync);
        @(negedge v_sync);
        rst = 1'b0;
        model_reset();

        for (int f = 0; f < 1500; f++) begin
            for (int i = 0; i < 5; i++) begin
                if (alive[i]) begin
                    if ($urandom_range(0, 99) < 25) alive[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 40) begin
                    alive[i] = 1'b1;
                end
            end
            if (lives != 2'd0 && $urandom_range(0, 59) == 0) lives = lives - 2'd1;
            else if (lives == 2'd0 && $urandom_range(0, 9) == 0) lives = 2'd3;
            start_btn = ($urandom_range(0, 11) == 0);
            pause_btn = ($urandom_range(0, 15) == 0);
            frame();
        end

        @(negedge v_sync);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected frames left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
